timing_phase_gen: RTL and testbench

//  Generates the four LVDA timing phases WDA, XDA, YDA, ZDA. The timing fan-out

---
 rtl/timing_phase_gen.sv | 168 ++++++++++++++++
 tb/tb_timing_phase_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_phase_gen.sv
// timing_phase_gen: sequences the four non-overlapping LVDA timing phases
// (WDA, XDA, YDA, ZDA) once per bit time and counts bit times within a word.
// Optional feature macro: TIMING_STEP_EN adds a STEP input that runs exactly
// one bit time from IDLE when RUN is low.
module timing_phase_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int GAP_CYCLES   = 1,
    parameter int BIT_TIMES    = 14,
    parameter int BT_W         = 4
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            RUN,
`ifdef TIMING_STEP_EN
    input  logic            STEP,
`endif
    output logic            WDA,
    output logic            XDA,
    output logic            YDA,
    output logic            ZDA,
    output logic [BT_W-1:0] BIT_TIME,
    output logic            BT_START,
    output logic            WORD_END,
    output logic            RUNNING
);

    // Counter is one bit wider than strictly needed so the "phase on" limit
    // (PHASE_CYCLES - GAP_CYCLES) is representable even when GAP_CYCLES = 0.
    localparam int CYC_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PHASE_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ON   = CYC_W'(PHASE_CYCLES - GAP_CYCLES);
    localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BIT_TIMES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [CYC_W-1:0]  cyc_q,      cyc_d;
    logic [1:0]        ph_q,       ph_d;
    logic [BT_W-1:0]   bit_time_q, bit_time_d;
    logic              wda_q,      wda_d;
    logic              xda_q,      xda_d;
    logic              yda_q,      yda_d;
    logic              zda_q,      zda_d;
    logic              bt_start_q, bt_start_d;
    logic              word_end_q, word_end_d;
    logic              running_q,  running_d;

    logic              start_s;
    logic              last_s;
    logic              active_s;
    logic              phase_on_s;

`ifdef TIMING_STEP_EN
    // STEP only matters in IDLE; while ACTIVE the start request is not looked at.
    assign start_s = RUN | STEP;
`else
    assign start_s = RUN;
`endif

    // Last cycle of a bit time: Z slot, final slot cycle.
    assign last_s = (ph_q == 2'd3) && (cyc_q == CYC_LAST);

    // State and output registers with synchronous reset.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            ph_q       <= 2'd0;
            bit_time_q <= '0;
            wda_q      <= 1'b0;
            xda_q      <= 1'b0;
            yda_q      <= 1'b0;
            zda_q      <= 1'b0;
            bt_start_q <= 1'b0;
            word_end_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            ph_q       <= ph_d;
            bit_time_q <= bit_time_d;
            wda_q      <= wda_d;
            xda_q      <= xda_d;
            yda_q      <= yda_d;
            zda_q      <= zda_d;
            bt_start_q <= bt_start_d;
            word_end_q <= word_end_d;
            running_q  <= running_d;
        end
    end

    // Next-state logic: slot/phase sequencing, bit-time count, run/stop decision.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        ph_d       = ph_q;
        bit_time_d = bit_time_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_ACTIVE;
                    cyc_d   = '0;
                    ph_d    = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                    ph_d    = 2'd0;
                end
            end
            ST_ACTIVE: begin
                if (last_s) begin
                    // Bit time completes; RUN decides whether the next one
                    // follows back-to-back or generation stops here.
                    if (bit_time_q == BT_LAST) begin
                        bit_time_d = '0;
                    end else begin
                        bit_time_d = bit_time_q + BT_W'(1);
                    end
                    cyc_d = '0;
                    ph_d  = 2'd0;
                    if (RUN) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    ph_d  = ph_q + 2'd1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cyc_d      = '0;
                ph_d       = 2'd0;
                bit_time_d = bit_time_q;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        active_s   = (state_d == ST_ACTIVE);
        phase_on_s = active_s && (cyc_d < CYC_ON);
        wda_d      = phase_on_s && (ph_d == 2'd0);
        xda_d      = phase_on_s && (ph_d == 2'd1);
        yda_d      = phase_on_s && (ph_d == 2'd2);
        zda_d      = phase_on_s && (ph_d == 2'd3);
        bt_start_d = active_s && (ph_d == 2'd0) && (cyc_d == '0);
        word_end_d = active_s && (ph_d == 2'd3) && (cyc_d == CYC_LAST)
                     && (bit_time_d == BT_LAST);
        running_d  = active_s;
    end

    assign WDA      = wda_q;
    assign XDA      = xda_q;
    assign YDA      = yda_q;
    assign ZDA      = zda_q;
    assign BIT_TIME = bit_time_q;
    assign BT_START = bt_start_q;
    assign WORD_END = word_end_q;
    assign RUNNING  = running_q;

endmodule

// File: tb/tb_timing_phase_gen.sv
// Bench for timing_phase_gen: instance 0 uses default parameters, instance 1
// uses GAP_CYCLES = 0. A cycle-position model predicts every output; directed
// literal checks pin the model, then randomized RUN/reset (and STEP) traffic.
module tb_timing_phase_gen;

    localparam int PC = 4;
    localparam int BT = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic [1:0] run_v;
    logic       chk_en;

    logic       w0, x0, y0, z0, bs0, we0, rn0;
    logic [3:0] bt0;
    logic       w1, x1, y1, z1, bs1, we1, rn1;
    logic [3:0] bt1;
    logic [10:0] got0, got1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: active flag, cycle position inside the bit time, bit count.
    bit m_act [2];
    int m_pos [2];
    int m_bt  [2];

    always #5 clk = ~clk;

    assign got0 = {z0, y0, x0, w0, bs0, we0, rn0, bt0};
    assign got1 = {z1, y1, x1, w1, bs1, we1, rn1, bt1};

    timing_phase_gen u_dut0 (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .RUN     (run_v[0]),
`ifdef TIMING_STEP_EN
        .STEP    (step),
`endif
        .WDA     (w0),
        .XDA     (x0),
        .YDA     (y0),
        .ZDA     (z0),
        .BIT_TIME(bt0),
        .BT_START(bs0),
        .WORD_END(we0),
        .RUNNING (rn0)
    );

    timing_phase_gen #(.GAP_CYCLES(0)) u_dut1 (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .RUN     (run_v[1]),
`ifdef TIMING_STEP_EN
        .STEP    (1'b0),
`endif
        .WDA     (w1),
        .XDA     (x1),
        .YDA     (y1),
        .ZDA     (z1),
        .BIT_TIME(bt1),
        .BT_START(bs1),
        .WORD_END(we1),
        .RUNNING (rn1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Expected output vector {Z,Y,X,W,BT_START,WORD_END,RUNNING,BIT_TIME}.
    function automatic logic [10:0] expv(input bit act, input int pos, input int bt, input int gap);
        logic [3:0] ph;
        logic       bs;
        logic       we;
        int         slot;
        int         cy;
        slot = pos / PC;
        cy   = pos % PC;
        ph   = 4'b0000;
        if (act && (cy < PC - gap)) ph = 4'b0001 << slot;
        bs = act && (pos == 0);
        we = act && (pos == 4 * PC - 1) && (bt == BT - 1);
        return {ph, bs, we, act, 4'(bt)};
    endfunction

    // Reference model advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= 1'b0;
                m_pos[i] <= 0;
                m_bt[i]  <= 0;
            end else if (!m_act[i]) begin
                if (run_v[i] || (i == 0 && step)) begin
                    m_act[i] <= 1'b1;
                    m_pos[i] <= 0;
                end
            end else if (m_pos[i] == 4 * PC - 1) begin
                m_bt[i]  <= (m_bt[i] + 1) % BT;
                m_pos[i] <= 0;
                m_act[i] <= run_v[i];
            end else begin
                m_pos[i] <= m_pos[i] + 1;
            end
        end
    end

    // Compare both instances against the model every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dut0", 32'(got0), 32'(expv(m_act[0], m_pos[0], m_bt[0], 1)));
            check("model_dut1", 32'(got1), 32'(expv(m_act[1], m_pos[1], m_bt[1], 0)));
            if (rn1) check("gap0_onehot", 32'($countones(got1[10:7])), 32'd1);
            else     check("gap0_idle_low", 32'(got1[10:7]), 32'd0);
        end
    end

    int wcount;
    int wfirst;
    int wsecond;
    int stepcnt;

    initial begin
        rst     = 1'b1;
        run_v   = 2'b00;
        step    = 1'b0;
        chk_en  = 1'b0;
        wcount  = 0;
        wfirst  = 0;
        wsecond = 0;
        stepcnt = 0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_all_zero", 32'(got0), 32'd0);

        // RUN rises here; the following rising edge is edge 0, and the
        // first falling edge seen in the loop lies in cycle 0.
        @(posedge clk);
        #1 run_v = 2'b11;
        for (int c = 0; c <= 620; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 448 && we0) begin
                wcount++;
                if (wcount == 1) wfirst = c;
                if (wcount == 2) wsecond = c;
            end
            case (c)
                0:   check("c0_idle", 32'(rn0), 32'd0);
                1: begin
                    check("c1_phases", 32'(got0[10:7]), 32'h1);
                    check("c1_bt_start", 32'(bs0), 32'd1);
                    check("c1_bit_time", 32'(bt0), 32'd0);
                end
                2:   check("c2_bt_start_low", 32'(bs0), 32'd0);
                4:   check("c4_gap", 32'(got0[10:7]), 32'h0);
                5:   check("c5_x", 32'(got0[10:7]), 32'h2);
                9:   check("c9_y", 32'(got0[10:7]), 32'h4);
                13:  check("c13_z", 32'(got0[10:7]), 32'h8);
                16: begin
                    check("c16_gap", 32'(got0[10:7]), 32'h0);
                    check("c16_bit_time", 32'(bt0), 32'd0);
                end
                17: begin
                    check("c17_bit_time", 32'(bt0), 32'd1);
                    check("c17_w", 32'(got0[10:7]), 32'h1);
                end
                224: check("c224_bit_time", 32'(bt0), 32'd13);
                225: check("c225_wrap", 32'(bt0), 32'd0);
                448: begin
                    check("word_end_count", 32'(wcount), 32'd2);
                    check("word_end_first", 32'(wfirst), 32'd224);
                    check("word_end_second", 32'(wsecond), 32'd448);
                end
                533: begin
                    check("c533_x_bit5", 32'({got0[10:7], bt0}), 32'h25);
                    run_v[0] = 1'b0;
                end
                544: check("c544_z_completes", 32'(rn0), 32'd1);
                545: begin
                    check("c545_idle", 32'(rn0), 32'd0);
                    check("c545_bit_time", 32'(bt0), 32'd6);
                    check("c545_phases", 32'(got0[10:7]), 32'h0);
                end
                550: begin
                    check("c550_held", 32'(bt0), 32'd6);
                    run_v[0] = 1'b1;
                end
                551: begin
                    check("c551_restart_bs", 32'(bs0), 32'd1);
                    check("c551_restart_bt", 32'(bt0), 32'd6);
                end
                560: begin
                    check("c560_y", 32'(got0[10:7]), 32'h4);
                    rst      = 1'b1;
                    run_v[0] = 1'b0;
                end
                561: begin
                    check("c561_reset", 32'(got0), 32'd0);
                    rst = 1'b0;
                end
`ifdef TIMING_STEP_EN
                570: step = 1'b1;
                571: step = 1'b0;
                575: step = 1'b1;
                576: step = 1'b0;
                620: begin
                    check("step_running_cycles", 32'(stepcnt), 32'd16);
                    check("step_bit_time", 32'(bt0), 32'd1);
                end
`endif
                default: ;
            endcase
            if (c >= 562 && c <= 569) check("post_reset_quiet", 32'(got0), 32'd0);
            if (c >= 571 && rn0) stepcnt++;
        end

        // Randomized RUN toggles, short RUN pulses, occasional resets.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) run_v[0] = ~run_v[0];
            if ($urandom_range(0, 39) == 0) run_v[1] = ~run_v[1];
            if ($urandom_range(0, 29) == 0) run_v = run_v ^ 2'b01;
`ifdef TIMING_STEP_EN
            step = ($urandom_range(0, 14) == 0);
`endif
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
